// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sits between the datapath bus and a 512x32 synchronous-read RAM.
// It holds the MAR and MDR and runs one read or write at a time using a req/done handshake.
// It absorbs the RAM's one-cycle registered read latency and WAIT_STATES extra idle cycles.
// Optional feature macro: MEM_BUSY_ERR_EN. When it is defined, a request made while busy sets the
// sticky mem_err flag. When it is undefined, mem_err is tied low.
module mem_access_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_in,
  input  logic              MDR_in,
  input  logic              mem_req,
  input  logic              mem_we,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic [DATA_W-1:0] MDR_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // A WAIT_STATES of zero skips the WAIT state entirely, so its load value is never used.
  localparam bit       HasWait  = (WAIT_STATES > 0);
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              weLat_q, weLat_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic              acceptReq;
  logic              busyState;

  assign busyState = (state_q == S_ACCESS) || (state_q == S_WAIT) || (state_q == S_CAPTURE);

  // Next-state, register-load and wait-counter logic. MAR/MDR loads happen only between transactions.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    weLat_d   = weLat_q;
    waitCnt_d = waitCnt_q;
    acceptReq = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (MAR_in) mar_d = bus_in[ADDR_W-1:0];
        if (MDR_in) mdr_d = bus_in;
        if (mem_req) begin
          acceptReq = 1'b1;
          weLat_d   = mem_we;
          state_d   = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (HasWait) begin
          waitCnt_d = WaitLoad;
          state_d   = S_WAIT;
        end else begin
          state_d = weLat_q ? S_DONE : S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = weLat_q ? S_DONE : S_CAPTURE;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        mdr_d   = ram_data_out;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. The clear is asynchronous, so an in-flight write drops at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      weLat_q   <= 1'b0;
      waitCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      weLat_q   <= weLat_d;
      waitCnt_q <= waitCnt_d;
    end
  end

`ifdef MEM_BUSY_ERR_EN
  logic err_q, err_d;

  // Sticky busy-request flag. It is cleared by the next request that is actually accepted.
  always_comb begin
    err_d = err_q;
    if (acceptReq) begin
      err_d = 1'b0;
    end else if (busyState && mem_req) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  // The handshake and RAM strobes decode only from registered state, so they cannot glitch.
  assign mem_busy    = busyState;
  assign mem_done    = (state_q == S_DONE);
  assign ram_read    = (state_q == S_ACCESS) && !weLat_q;
  assign ram_write   = (state_q == S_ACCESS) && weLat_q;
  assign MDR_out     = mdr_q;
  assign ram_addr    = mar_q;
  assign ram_data_in = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl. It drives two instances at once:
// dev0 uses WAIT_STATES=0 and dev1 uses WAIT_STATES=3.
// Each instance has its own behavioural synchronous-read RAM.
// Stimulus pushes the expected MDR value and done cycle into a queue for each device.
// A separate monitor pops that queue whenever mem_done is seen.
module tb_mem_access_ctrl;

  localparam int WaitA = 0;
  localparam int WaitB = 3;
`ifdef MEM_BUSY_ERR_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          doneCyc;
  } exp_t;

  logic        clk;
  logic        clr;
  logic [31:0] busIn [2];
  logic [1:0]  marIn;
  logic [1:0]  mdrIn;
  logic [1:0]  memReq;
  logic [1:0]  memWe;
  wire  [1:0]  memBusy;
  wire  [1:0]  memDone;
  wire  [1:0]  memErr;
  wire  [1:0]  ramRead;
  wire  [1:0]  ramWrite;
  wire  [31:0] mdrOut [2];
  wire  [31:0] ramDataIn [2];
  wire  [31:0] ramDataOut [2];
  wire  [8:0]  ramAddr [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rdCnt [2] = '{0, 0};
  int   wrCnt [2] = '{0, 0};
  int   busyCnt [2] = '{0, 0};
  int   expMar [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(WaitA)) dut0 (
    .clk(clk), .clr(clr), .bus_in(busIn[0]), .MAR_in(marIn[0]), .MDR_in(mdrIn[0]),
    .mem_req(memReq[0]), .mem_we(memWe[0]), .mem_busy(memBusy[0]), .mem_done(memDone[0]),
    .mem_err(memErr[0]), .MDR_out(mdrOut[0]), .ram_addr(ramAddr[0]), .ram_data_in(ramDataIn[0]),
    .ram_read(ramRead[0]), .ram_write(ramWrite[0]), .ram_data_out(ramDataOut[0])
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(WaitB)) dut1 (
    .clk(clk), .clr(clr), .bus_in(busIn[1]), .MAR_in(marIn[1]), .MDR_in(mdrIn[1]),
    .mem_req(memReq[1]), .mem_we(memWe[1]), .mem_busy(memBusy[1]), .mem_done(memDone[1]),
    .mem_err(memErr[1]), .MDR_out(mdrOut[1]), .ram_addr(ramAddr[1]), .ram_data_in(ramDataIn[1]),
    .ram_read(ramRead[1]), .ram_write(ramWrite[1]), .ram_data_out(ramDataOut[1])
  );

  // Words that have never been written read back as a recognisable address pattern.
  function automatic logic [31:0] pat(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  function automatic int waitOf(input int d);
    return (d == 0) ? WaitA : WaitB;
  endfunction

  // Free-running clock and a cycle counter used as the latency reference.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One synchronous-read RAM model per device. Data_out is registered and holds between reads.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [31:0] mem [int];
    logic [31:0] dout = 32'h0;
    always @(posedge clk) begin
      if (ramWrite[g]) mem[int'(ramAddr[g])] = ramDataIn[g];
      if (ramRead[g]) dout <= mem.exists(int'(ramAddr[g])) ? mem[int'(ramAddr[g])] : pat(ramAddr[g]);
    end
    assign ramDataOut[g] = dout;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts strobe cycles and compares each mem_done against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rdCnt[d]   = rdCnt[d] + (ramRead[d] ? 1 : 0);
      wrCnt[d]   = wrCnt[d] + (ramWrite[d] ? 1 : 0);
      busyCnt[d] = busyCnt[d] + (memBusy[d] ? 1 : 0);
      if (clr && memDone[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("[TB] FAIL dev%0d unexpected mem_done: got 1, expected 0", d);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          checkOutput($sformatf("dev%0d MDR_out at done", d), mdrOut[d], e.data);
          checkOutput($sformatf("dev%0d done cycle", d), cyc, e.doneCyc);
        end
      end
    end
  end

  // Every stimulus task starts and ends just after a falling edge.
  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Load MAR (isMar=1) or MDR from the bus on the next rising edge, then check the result.
  task automatic loadRegs(input int d, input logic isMar, input logic [31:0] val);
    busIn[d] = val;
    marIn[d] = isMar;
    mdrIn[d] = !isMar;
    @(negedge clk);
    marIn[d] = 1'b0;
    mdrIn[d] = 1'b0;
    if (isMar) begin
      expMar[d] = int'(val[8:0]);
      checkOutput($sformatf("dev%0d ram_addr after MAR load", d), 32'(ramAddr[d]), 32'(expMar[d]));
    end else begin
      checkOutput($sformatf("dev%0d MDR_out after MDR load", d), mdrOut[d], val);
      checkOutput($sformatf("dev%0d ram_data_in after MDR load", d), ramDataIn[d], val);
    end
  endtask

  // Issue one transaction, optionally loading MAR on the accepting edge.
  // pokeAt >= 0 injects a busy request on that falling edge of the busy window. The poke also asserts
  // MAR_in/MDR_in with a junk bus value, which must be ignored.
  task automatic applyStimulus(input int d, input logic we, input logic loadMar,
                               input logic [31:0] marVal, input logic [31:0] expData, input int pokeAt);
    exp_t e;
    int   k;
    int   rd0, wr0, busy0;
    logic poked;
    rd0 = rdCnt[d]; wr0 = wrCnt[d]; busy0 = busyCnt[d];
    poked = 1'b0;
    memReq[d] = 1'b1;
    memWe[d]  = we;
    if (loadMar) begin
      busIn[d]  = marVal;
      marIn[d]  = 1'b1;
      expMar[d] = int'(marVal[8:0]);
    end
    @(posedge clk);
    #1;
    e.data    = expData;
    e.doneCyc = cyc + (we ? 1 : 2) + waitOf(d);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    checkOutput($sformatf("dev%0d busy in ACCESS", d), 32'(memBusy[d]), 32'd1);
    checkOutput($sformatf("dev%0d ram_write in ACCESS", d), 32'(ramWrite[d]), 32'(we));
    checkOutput($sformatf("dev%0d ram_read in ACCESS", d), 32'(ramRead[d]), 32'(!we));
    checkOutput($sformatf("dev%0d ram_addr in ACCESS", d), 32'(ramAddr[d]), 32'(expMar[d]));
    checkOutput($sformatf("dev%0d mem_err after accept", d), 32'(memErr[d]), 32'd0);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      marIn[d] = 1'b0; mdrIn[d] = 1'b0; memReq[d] = 1'b0; memWe[d] = 1'b0;
      if (memDone[d]) break;
      if (k == pokeAt) begin
        busIn[d] = 32'hBAD0_BAD0;
        marIn[d] = 1'b1; mdrIn[d] = 1'b1; memReq[d] = 1'b1; memWe[d] = 1'b1;
        poked = 1'b1;
      end
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL dev%0d done timeout: got no mem_done, expected within 50 cycles", d);
    end
    checkOutput($sformatf("dev%0d busy cycles", d), busyCnt[d] - busy0, (we ? 1 : 2) + waitOf(d));
    checkOutput($sformatf("dev%0d ram_read cycles", d), rdCnt[d] - rd0, we ? 0 : 1);
    checkOutput($sformatf("dev%0d ram_write cycles", d), wrCnt[d] - wr0, we ? 1 : 0);
    checkOutput($sformatf("dev%0d ram_addr at done", d), 32'(ramAddr[d]), 32'(expMar[d]));
    checkOutput($sformatf("dev%0d mem_err at done", d), 32'(memErr[d]), poked ? 32'(ErrExp) : 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    clr = 1'b0;
    marIn = '0; mdrIn = '0; memReq = '0; memWe = '0;
    busIn[0] = '0; busIn[1] = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dev%0d reset busy", d), 32'(memBusy[d]), 32'd0);
      checkOutput($sformatf("dev%0d reset done", d), 32'(memDone[d]), 32'd0);
      checkOutput($sformatf("dev%0d reset err", d), 32'(memErr[d]), 32'd0);
      checkOutput($sformatf("dev%0d reset strobes", d), {30'd0, ramRead[d], ramWrite[d]}, 32'd0);
      checkOutput($sformatf("dev%0d reset MDR", d), mdrOut[d], 32'd0);
      checkOutput($sformatf("dev%0d reset MAR", d), 32'(ramAddr[d]), 32'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    idleCycles(1);

    // Clear arriving in the middle of a write aborts it, and the target word must stay untouched.
    loadRegs(0, 1'b1, 32'h0000_0040);
    loadRegs(0, 1'b0, 32'h1111_2222);
    memReq[0] = 1'b1;
    memWe[0]  = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort ram_write in ACCESS", 32'(ramWrite[0]), 32'd1);
    #2;
    clr = 1'b0;
    memReq[0] = 1'b0;
    memWe[0]  = 1'b0;
    #1;
    checkOutput("abort ram_write after clr", 32'(ramWrite[0]), 32'd0);
    checkOutput("abort busy after clr", 32'(memBusy[0]), 32'd0);
    checkOutput("abort done after clr", 32'(memDone[0]), 32'd0);
    checkOutput("abort MAR after clr", 32'(ramAddr[0]), 32'd0);
    checkOutput("abort MDR after clr", mdrOut[0], 32'd0);
    @(negedge clk);
    clr = 1'b1;
    expMar[0] = 0;
    expMar[1] = 0;
    idleCycles(1);

    // Device 0 (no wait states): write, then read it back into a cleared MDR.
    loadRegs(0, 1'b1, 32'h0000_012C);
    loadRegs(0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF, -1);
    idleCycles(1);
    loadRegs(0, 1'b0, 32'h0000_0000);
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, -1);
    idleCycles(1);

    // MAR load on the accepting edge. A back-to-back read then checks the aborted word was never written.
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0052, pat(9'h052), -1);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0040, pat(9'h040), -1);
    idleCycles(1);

    // Upper bus bits are dropped on a MAR load. Junk loads during CAPTURE must not reach MAR or MDR.
    loadRegs(0, 1'b1, 32'hFFFF_F1AB);
    loadRegs(0, 1'b0, 32'h0123_4567);
    applyStimulus(0, 1'b1, 1'b0, 32'd0, 32'h0123_4567, -1);
    loadRegs(0, 1'b0, 32'h0000_0000);
    applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'h0123_4567, 1);
    idleCycles(1);

    // Device 1 (three wait states): a plain read first.
    loadRegs(1, 1'b1, 32'h0000_000A);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, pat(9'h00A), -1);
    idleCycles(1);

    // A request arriving during WAIT is dropped. The next read is issued back-to-back from DONE,
    // and junk MAR/MDR loads arrive during its CAPTURE.
    loadRegs(1, 1'b1, 32'h0000_0010);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, pat(9'h010), 2);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0020, pat(9'h020), 4);
    idleCycles(1);

    // Write with wait states, then read back. The MDR clear happens in DONE, where loads are allowed.
    loadRegs(1, 1'b0, 32'h5555_AAAA);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_00AA, 32'h5555_AAAA, -1);
    loadRegs(1, 1'b0, 32'h0000_0000);
    applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'h5555_AAAA, -1);
    idleCycles(2);

    checkOutput("dev0 scoreboard drained", q0.size(), 32'd0);
    checkOutput("dev1 scoreboard drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
